// File: rtl/mprj_wb_fifo_if.sv
// Wishbone user-bus bundle between the management core and the FIFO mailbox.
// Signal names follow the core's exported wbs_* naming.
interface mprj_wb_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/mprj_wb_fifo.sv
// Wishbone slave FIFO mailbox: 32-bit word FIFO with CTRL/STATUS/IRQ_STAT registers
// and a user IRQ built purely from flops.
module mprj_wb_fifo #(
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic     wb_clk_i,
    input  logic     wb_rst_i,
    mprj_wb_if.slave wbs,
    output logic     user_irq
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         count, count_nxt;
    logic                  irq_en;
    logic [6:0]            thresh;
    logic [2:0]            irq_stat, irq_stat_nxt, irq_set, irq_clr;

    logic        in_win, accept;
    logic [7:0]  offset;
    logic        push, pop, ctrl_wr, stat_w1c, clear;
    logic        do_push, do_pop;
    logic        empty, full;
    logic [31:0] status, ctrl_rd, rdata;

    logic unused_sel;
    assign unused_sel = ^wbs.wbs_sel_i[3:2];

    always_comb begin
        in_win   = (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
        accept   = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~wbs.wbs_ack_o & in_win;
        offset   = wbs.wbs_adr_i[7:0];
        push     = accept &  wbs.wbs_we_i & (offset == 8'h00);
        pop      = accept & ~wbs.wbs_we_i & (offset == 8'h00);
        ctrl_wr  = accept &  wbs.wbs_we_i & (offset == 8'h08);
        stat_w1c = accept &  wbs.wbs_we_i & (offset == 8'h0C);
        clear    = ctrl_wr & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[1];

        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        do_push = push & ~full;
        do_pop  = pop & ~empty;

        count_nxt = count;
        if (clear)
            count_nxt = '0;
        else if (do_push)
            count_nxt = count + CW'(1);
        else if (do_pop)
            count_nxt = count - CW'(1);

        // Set sources win over a simultaneous W1C of the same bit.
        irq_set[0] = (thresh != 7'd0) && (32'(count_nxt) >= 32'(thresh));
        irq_set[1] = push & full;
        irq_set[2] = pop & empty;
        irq_clr    = stat_w1c ? wbs.wbs_dat_i[2:0] : 3'b000;
        irq_stat_nxt = (irq_stat & ~irq_clr) | irq_set;

        status           = '0;
        status[0]        = empty;
        status[1]        = full;
        status[8 +: CW]  = count;

        ctrl_rd          = '0;
        ctrl_rd[0]       = irq_en;
        ctrl_rd[14:8]    = thresh;

        case (offset)
            8'h00:   rdata = empty ? 32'h0 : mem[rd_ptr];
            8'h04:   rdata = status;
            8'h08:   rdata = ctrl_rd;
            8'h0C:   rdata = {29'h0, irq_stat};
            default: rdata = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= 32'h0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            irq_en        <= 1'b0;
            thresh        <= 7'd0;
            irq_stat      <= 3'b000;
        end else begin
            wbs.wbs_ack_o <= accept;
            wbs.wbs_dat_o <= (accept & ~wbs.wbs_we_i) ? rdata : 32'h0;
            count         <= count_nxt;
            irq_stat      <= irq_stat_nxt;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
            if (ctrl_wr && wbs.wbs_sel_i[0])
                irq_en <= wbs.wbs_dat_i[0];
            if (ctrl_wr && wbs.wbs_sel_i[1])
                thresh <= wbs.wbs_dat_i[14:8];
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge wb_clk_i) begin
        if (do_push)
            mem[wr_ptr] <= wbs.wbs_dat_i;
    end

    assign user_irq = irq_en & (|irq_stat);

endmodule

// File: tb/tb_mprj_wb_fifo.sv
// Scoreboard bench for mprj_wb_fifo: expected read data is queued at issue and
// compared when the ack arrives.
module tb_mprj_wb_fifo;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_DATA = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_CTRL = BASE + 32'h08;
    localparam logic [31:0] A_IRQS = BASE + 32'h0C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic user_irq;

    mprj_wb_if wb ();

    mprj_wb_fifo #(.BASE_ADR(BASE), .DEPTH_LOG2(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (wb.slave),
        .user_irq (user_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus(input string tag, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] exp_rd);
        int lat;
        logic [31:0] e;
        exp_q.push_back(we ? 32'h0 : exp_rd);
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (wb.wbs_ack_o !== 1'b1 && lat < 4);
        e = exp_q.pop_front();
        chk({tag, "_ack"}, {31'h0, wb.wbs_ack_o}, 32'h1);
        if (wb.wbs_ack_o === 1'b1) begin
            chk({tag, "_lat"}, 32'(lat), 32'd1);
            chk(tag, wb.wbs_dat_o, e);
        end
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_drop"}, {31'h0, wb.wbs_ack_o}, 32'h0);
    endtask

    task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel = 4'hF);
        bus(tag, 1'b1, adr, dat, sel, 32'h0);
    endtask

    task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        bus(tag, 1'b0, adr, 32'h0, 4'hF, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = 32'h0;
        wb.wbs_dat_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
        chk("rst_dat", wb.wbs_dat_o, 32'h0);
        chk("rst_irq", {31'h0, user_irq}, 32'h0);
        rst = 1'b0;

        rd("status_rst", A_STAT, 32'h0000_0001);
        rd("ctrl_rst", A_CTRL, 32'h0);

        for (int i = 0; i < 16; i++) wr("push", A_DATA, 32'hA0 + 32'(i));
        rd("status_full", A_STAT, 32'h0000_1002);
        wr("push_over", A_DATA, 32'hFF);
        rd("irqs_over", A_IRQS, 32'h2);
        for (int i = 0; i < 16; i++) rd("pop", A_DATA, 32'hA0 + 32'(i));
        rd("status_empty", A_STAT, 32'h1);

        wr("w1c_over", A_IRQS, 32'h2);
        rd("pop_empty", A_DATA, 32'h0);
        rd("irqs_under", A_IRQS, 32'h4);
        wr("w1c_under", A_IRQS, 32'h4);
        rd("irqs_clr", A_IRQS, 32'h0);

        wr("ctrl_set", A_CTRL, 32'h0000_0301);
        rd("ctrl_rb", A_CTRL, 32'h0000_0301);
        wr("push_t", A_DATA, 32'hB0);
        wr("push_t", A_DATA, 32'hB1);
        chk("irq_below", {31'h0, user_irq}, 32'h0);
        wr("push_t", A_DATA, 32'hB2);
        chk("irq_hit", {31'h0, user_irq}, 32'h1);
        rd("irqs_hit", A_IRQS, 32'h1);
        wr("w1c_hold", A_IRQS, 32'h1);
        rd("irqs_hold", A_IRQS, 32'h1);
        rd("pop_t", A_DATA, 32'hB0);
        wr("w1c_thr", A_IRQS, 32'h1);
        rd("irqs_thr_clr", A_IRQS, 32'h0);
        chk("irq_low", {31'h0, user_irq}, 32'h0);

        wr("ctrl_lane0", A_CTRL, 32'h0000_0501, 4'b0001);
        rd("ctrl_lane0_rb", A_CTRL, 32'h0000_0301);
        for (int i = 0; i < 3; i++) wr("push_c", A_DATA, 32'hD0 + 32'(i));
        rd("status_five", A_STAT, 32'h0000_0500);
        wr("ctrl_clear", A_CTRL, 32'h2);
        rd("status_cleared", A_STAT, 32'h1);
        rd("ctrl_after_clr", A_CTRL, 32'h0);
        rd("unmapped", BASE + 32'h10, 32'h0);

        // Out-of-window push attempt must never be acked nor touch the FIFO.
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_sel_i = 4'hF;
        wb.wbs_adr_i = BASE + 32'h100;
        wb.wbs_dat_i = 32'h1234_5678;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (wb.wbs_ack_o !== 1'b0) seen = 1'b1;
        end
        chk("oow_ack", {31'h0, seen}, 32'h0);
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        rd("status_oow", A_STAT, 32'h1);

        wr("push_r", A_DATA, 32'hC0);
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = A_DATA;
        @(negedge clk);
        chk("rst_pre_ack", {31'h0, wb.wbs_ack_o}, 32'h1);
        chk("rst_pre_dat", wb.wbs_dat_o, 32'hC0);
        rst = 1'b1;
        #1;
        chk("rst_mid_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
        chk("rst_mid_dat", wb.wbs_dat_o, 32'h0);
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd("status_post_rst", A_STAT, 32'h1);
        chk("irq_post_rst", {31'h0, user_irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
